pipe_skid_reg: RTL

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg.sv | 115 +++++++++++
 1 files changed

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry pipeline register with a skid buffer.
// Every output comes straight from a flop, so in_ready and out_valid have no
// combinational path from in_valid or out_ready.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   flush      synchronous discard of all held entries (active-high)
//   in_valid   upstream offers in_data
//   in_ready   stage can accept a word this cycle
//   in_data    upstream data word
//   out_valid  out_data holds a valid word
//   out_ready  downstream accepts out_data this cycle
//   out_data   head-of-stage word (main register M)
//   occupancy  number of held entries (0..2), equal to the state encoding
module pipe_skid_reg #(
    parameter int unsigned           WIDTH     = 32,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    localparam int unsigned OCC_W = 2;

    typedef enum logic [OCC_W-1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_nxt;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] m_nxt;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] s_nxt;
    logic             out_valid_q;
    logic             in_ready_q;
    logic             push;
    logic             pop;

    assign push = in_valid & in_ready_q;
    assign pop  = out_valid_q & out_ready;

    // Next-state and datapath decode; flush forces EMPTY and leaves M/S alone.
    always_comb begin
        state_nxt = state_q;
        m_nxt     = m_q;
        s_nxt     = s_q;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_nxt = HALF;
                        m_nxt     = in_data;
                    end
                end
                HALF: begin
                    if (push && pop) begin
                        m_nxt = in_data;
                    end else if (push) begin
                        state_nxt = FULL;
                        s_nxt     = in_data;
                    end else if (pop) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a pop can occur.
                    if (pop) begin
                        state_nxt = HALF;
                        m_nxt     = s_q;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

    // State, data and handshake flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= EMPTY;
            m_q         <= RESET_VAL;
            s_q         <= RESET_VAL;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_nxt;
            m_q         <= m_nxt;
            s_q         <= s_nxt;
            out_valid_q <= (state_nxt != EMPTY);
            in_ready_q  <= (state_nxt != FULL);
        end
    end

    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign out_data  = m_q;
    assign occupancy = OCC_W'(state_q);

endmodule
